// File: rtl/sysid_chk_pkg.sv
// Shared types and constants for the sysid boot-check sequencer.
package sysid_chk_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRdId,
        StWtId,
        StRdTs,
        StWtTs,
        StCmp,
        StDone
    } state_e;

    localparam int unsigned FC_ID = 0;
    localparam int unsigned FC_TS = 1;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

endpackage

// File: rtl/sysid_chk_rd_port.sv
// Avalon-MM read port: one read strobe per go, rd_done when data is valid
// READ_LATENCY cycles later (same cycle when READ_LATENCY is 0).
module sysid_chk_rd_port #(
    parameter int unsigned READ_LATENCY = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        go,
    input  logic        addr,
    output logic        rd_done,
    output logic [31:0] rd_data,
    output logic        av_address,
    output logic        av_read,
    input  logic [31:0] av_readdata
);

    localparam logic [2:0] Lat = 3'(READ_LATENCY);

    logic       addr_q, addr_d;
    logic [2:0] cnt_q, cnt_d;

    always_comb begin
        addr_d = go ? addr : addr_q;
        cnt_d  = cnt_q;
        if (go) begin
            cnt_d = Lat;
        end else if (cnt_q != 3'd0) begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q <= 1'b0;
            cnt_q  <= 3'd0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Counter is loaded with the latency on the strobe and hits 1 on the data cycle.
    assign rd_done    = (Lat == 3'd0) ? go : (cnt_q == 3'd1);
    assign rd_data    = av_readdata;
    assign av_read    = go;
    assign av_address = addr_d;

endmodule

// File: rtl/sysid_check_ctrl.sv
// Boot-time sysid check sequencer: reads ID and timestamp, compares, retries, reports.
// Optional periodic re-check after a pass is enabled by defining SYSID_CHK_PERIODIC_EN.
module sysid_check_ctrl
    import sysid_chk_pkg::*;
#(
    parameter logic [31:0] EXP_ID         = 32'd0,
    parameter logic [31:0] EXP_TIMESTAMP  = 32'd1393714090,
    parameter int unsigned READ_LATENCY   = 0,
    parameter int unsigned MAX_RETRIES    = 2,
    parameter int unsigned RECHECK_CYCLES = 1000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        av_address,
    output logic        av_read,
    input  logic [31:0] av_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [1:0]  fail_code,
    output logic [31:0] id_seen,
    output logic [31:0] ts_seen,
    output logic [3:0]  retry_cnt
);

    localparam logic [3:0] MaxRetries = 4'(MAX_RETRIES);

    state_e      state_q, state_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [1:0]  fc_q, fc_d;
    logic [31:0] id_q, id_d;
    logic [31:0] ts_q, ts_d;
    logic [3:0]  retry_q, retry_d;

    logic        rd_go, rd_addr, rd_done;
    logic [31:0] rd_data;
    logic [1:0]  fc_now;
    logic        recheck_go;

    assign rd_go   = (state_q == StRdId) || (state_q == StRdTs);
    assign rd_addr = (state_q == StRdTs) ? ADDR_TS : ADDR_ID;

    sysid_chk_rd_port #(
        .READ_LATENCY(READ_LATENCY)
    ) u_rd_port (
        .clock      (clock),
        .reset      (reset),
        .go         (rd_go),
        .addr       (rd_addr),
        .rd_done    (rd_done),
        .rd_data    (rd_data),
        .av_address (av_address),
        .av_read    (av_read),
        .av_readdata(av_readdata)
    );

    always_comb begin
        fc_now        = 2'b00;
        fc_now[FC_ID] = (id_q != EXP_ID);
        fc_now[FC_TS] = (ts_q != EXP_TIMESTAMP);
    end

`ifdef SYSID_CHK_PERIODIC_EN
    localparam logic [31:0] RecheckLast = 32'(RECHECK_CYCLES - 1);

    logic [31:0] timer_q, timer_d;

    assign recheck_go = (state_q == StDone) && pass_q && (timer_q == RecheckLast);

    // Runs only while parked in DONE with a pass; any exit clears it.
    always_comb begin
        timer_d = 32'd0;
        if (state_q == StDone && pass_q && state_d == StDone) begin
            timer_d = (timer_q == 32'hFFFF_FFFF) ? timer_q : timer_q + 32'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer_q <= 32'd0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    logic unused_recheck_cycles;

    assign recheck_go            = 1'b0;
    assign unused_recheck_cycles = ^32'(RECHECK_CYCLES);
`endif

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        fc_d    = fc_q;
        id_d    = id_q;
        ts_d    = ts_q;
        retry_d = retry_q;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRdId;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    fc_d    = 2'b00;
                    retry_d = 4'd0;
                end else if (recheck_go) begin
                    // Self-start keeps the previous result visible until the new one lands.
                    state_d = StRdId;
                    busy_d  = 1'b1;
                    retry_d = 4'd0;
                end
            end
            StRdId, StWtId: begin
                if (rd_done) begin
                    id_d    = rd_data;
                    state_d = StRdTs;
                end else begin
                    state_d = StWtId;
                end
            end
            StRdTs, StWtTs: begin
                if (rd_done) begin
                    ts_d    = rd_data;
                    state_d = StCmp;
                end else begin
                    state_d = StWtTs;
                end
            end
            StCmp: begin
                if (fc_now == 2'b00 || retry_q >= MaxRetries) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (fc_now == 2'b00);
                    fc_d    = fc_now;
                end else begin
                    retry_d = retry_q + 4'd1;
                    state_d = StRdId;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fc_q    <= 2'b00;
            id_q    <= 32'd0;
            ts_q    <= 32'd0;
            retry_q <= 4'd0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fc_q    <= fc_d;
            id_q    <= id_d;
            ts_q    <= ts_d;
            retry_q <= retry_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_code = fc_q;
    assign id_seen   = id_q;
    assign ts_seen   = ts_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Bench for sysid_check_ctrl: two instances (latency 0 and 3) sharing a scripted sysid slave.
module tb_sysid_check_ctrl;

    localparam logic [31:0] EXP_ID = 32'h5A5A_0001;
    localparam logic [31:0] EXP_TS = 32'd1393714090;
    localparam int          MR     = 2;
    localparam int          RC     = 20;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    int   sel = 0;

    always #5 clk = ~clk;

    logic [31:0] rdata;
    logic        start0, start1;
    logic        adr0, rd0, busy0, done0, pass0;
    logic        adr1, rd1, busy1, done1, pass1;
    logic [1:0]  fc0, fc1;
    logic [31:0] ids0, ids1, tss0, tss1;
    logic [3:0]  rc0, rc1;

    assign start0 = start && (sel == 0);
    assign start1 = start && (sel == 1);

    sysid_check_ctrl #(
        .EXP_ID(EXP_ID), .EXP_TIMESTAMP(EXP_TS), .READ_LATENCY(0),
        .MAX_RETRIES(MR), .RECHECK_CYCLES(RC)
    ) dut0 (
        .clock(clk), .reset(rst), .start(start0), .av_address(adr0), .av_read(rd0),
        .av_readdata(rdata), .busy(busy0), .done(done0), .pass(pass0), .fail_code(fc0),
        .id_seen(ids0), .ts_seen(tss0), .retry_cnt(rc0)
    );

    sysid_check_ctrl #(
        .EXP_ID(EXP_ID), .EXP_TIMESTAMP(EXP_TS), .READ_LATENCY(3),
        .MAX_RETRIES(MR), .RECHECK_CYCLES(RC)
    ) dut1 (
        .clock(clk), .reset(rst), .start(start1), .av_address(adr1), .av_read(rd1),
        .av_readdata(rdata), .busy(busy1), .done(done1), .pass(pass1), .fail_code(fc1),
        .id_seen(ids1), .ts_seen(tss1), .retry_cnt(rc1)
    );

    logic        s_read, s_addr, s_busy, s_done, s_pass;
    logic [1:0]  s_fc;
    logic [31:0] s_ids, s_tss;
    logic [3:0]  s_rc;
    int          lat;

    always_comb begin
        lat    = (sel == 1) ? 3 : 0;
        s_read = (sel == 1) ? rd1 : rd0;
        s_addr = (sel == 1) ? adr1 : adr0;
        s_busy = (sel == 1) ? busy1 : busy0;
        s_done = (sel == 1) ? done1 : done0;
        s_pass = (sel == 1) ? pass1 : pass0;
        s_fc   = (sel == 1) ? fc1 : fc0;
        s_ids  = (sel == 1) ? ids1 : ids0;
        s_tss  = (sel == 1) ? tss1 : tss0;
        s_rc   = (sel == 1) ? rc1 : rc0;
    end

    // Scripted slave: attempt a returns a bad ID while a < bad_id_n, bad TS while a < bad_ts_n.
    // Data is only valid on the cycle the latency says; garbage otherwise.
    int          id_reads = 0;
    int          bad_id_n = 0;
    int          bad_ts_n = 0;
    logic [31:0] bad_id_val = 32'd0;
    logic [31:0] bad_ts_val = 32'd0;
    logic [31:0] garb = 32'hDEAD_BEEF;
    logic        lat_addr = 1'b0;
    int          lat_att = 0;
    int          pcnt = 0;
    logic        slave_clr = 1'b0;
    logic        sl_v, sl_a;
    int          sl_att;

    always @(posedge clk) begin
        garb <= $urandom;
        if (slave_clr) begin
            id_reads <= 0;
            pcnt     <= 0;
        end else if (s_read) begin
            lat_addr <= s_addr;
            lat_att  <= s_addr ? id_reads - 1 : id_reads;
            if (!s_addr) id_reads <= id_reads + 1;
            pcnt <= 1;
        end else if (pcnt != 0 && pcnt < 8) begin
            pcnt <= pcnt + 1;
        end
    end

    always_comb begin
        if (lat == 0) begin
            sl_v   = s_read;
            sl_a   = s_addr;
            sl_att = s_addr ? id_reads - 1 : id_reads;
        end else begin
            sl_v   = (pcnt == lat);
            sl_a   = lat_addr;
            sl_att = lat_att;
        end
        if (!sl_v)      rdata = garb;
        else if (!sl_a) rdata = (sl_att < bad_id_n) ? bad_id_val : EXP_ID;
        else            rdata = (sl_att < bad_ts_n) ? bad_ts_val : EXP_TS;
    end

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        slave_clr = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        slave_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({rd0, adr0, busy0, done0, pass0, fc0, ids0, tss0, rc0} !== '0 ||
            {rd1, adr1, busy1, done1, pass1, fc1, ids1, tss1, rc1} !== '0) begin
            errors++;
            $display("FAIL reset_state: dut0 busy=%0b done=%0b pass=%0b fc=%0b dut1 busy=%0b done=%0b, all required 0",
                     busy0, done0, pass0, fc0, busy1, done1);
        end
        rst = 1'b0;
    endtask

    // Runs one check and compares against the closed-form outcome of the retry rules.
    task automatic run_check(input int s, input int bid, input int bts, input logic [31:0] bidv,
                             input logic [31:0] btsv, input bit do_rst, input bit extra,
                             input string name);
        int          L, retries, exp_done, done_at;
        bit          exp_pass;
        logic [1:0]  exp_fc;
        logic [31:0] exp_ids, exp_tss;
        int          strobes[$];
        int          exp_strobes[$];

        sel        = s;
        L          = (s == 1) ? 3 : 0;
        bad_id_n   = bid;
        bad_ts_n   = bts;
        bad_id_val = bidv;
        bad_ts_val = btsv;
        if (do_rst) begin
            do_reset();
        end else begin
            @(negedge clk);
            slave_clr = 1'b1;
            @(negedge clk);
            slave_clr = 1'b0;
        end

        retries  = (bid > bts) ? bid : bts;
        if (retries > MR) retries = MR;
        exp_pass = (retries >= bid) && (retries >= bts);
        exp_fc   = {retries < bts, retries < bid};
        exp_ids  = (retries < bid) ? bidv : EXP_ID;
        exp_tss  = (retries < bts) ? btsv : EXP_TS;
        exp_done = 4 + 2 * L + retries * (3 + 2 * L);
        for (int a = 0; a <= retries; a++) begin
            exp_strobes.push_back(1 + a * (3 + 2 * L));
            exp_strobes.push_back(2 + L + a * (3 + 2 * L));
        end

        start   = 1'b1;
        done_at = -1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            start = extra && (n == 2 || n == 5);
            if (s_read) strobes.push_back(n);
            if (n == 1) begin
                checks++;
                if (s_busy !== 1'b1 || s_done !== 1'b0) begin
                    errors++;
                    $display("FAIL %s busy_after_start: busy=%0b done=%0b, required busy=1 done=0",
                             name, s_busy, s_done);
                end
            end
            if (s_done === 1'b1) begin
                done_at = n;
                break;
            end
        end
        start = 1'b0;

        checks++;
        if (done_at != exp_done) begin
            errors++;
            $display("FAIL %s done_cycle: got %0d, required %0d (-1 = timeout)", name, done_at,
                     exp_done);
        end
        checks++;
        if (s_busy !== 1'b0 || s_pass !== exp_pass || s_fc !== exp_fc) begin
            errors++;
            $display("FAIL %s result: busy=%0b pass=%0b fc=%b, required busy=0 pass=%0b fc=%b",
                     name, s_busy, s_pass, s_fc, exp_pass, exp_fc);
        end
        checks++;
        if (s_rc !== 4'(retries)) begin
            errors++;
            $display("FAIL %s retry_cnt: got %0d, required %0d", name, s_rc, retries);
        end
        checks++;
        if (s_ids !== exp_ids || s_tss !== exp_tss) begin
            errors++;
            $display("FAIL %s seen_words: id=%h ts=%h, required id=%h ts=%h", name, s_ids, s_tss,
                     exp_ids, exp_tss);
        end
        checks++;
        if (strobes != exp_strobes) begin
            errors++;
            $display("FAIL %s read_strobes: got %0d strobes first at %0d, required %0d first at %0d",
                     name, strobes.size(), (strobes.size() > 0) ? strobes[0] : -1,
                     exp_strobes.size(), exp_strobes[0]);
        end
    endtask

    task automatic test_match();
        run_check(0, 0, 0, 32'd0, 32'd0, 1'b1, 1'b0, "match_l0");
    endtask

    task automatic test_ts_mismatch();
        run_check(0, 0, 5, 32'd0, 32'h1234_5678, 1'b1, 1'b0, "ts_mismatch");
    endtask

    task automatic test_id_retry_once();
        run_check(0, 1, 0, 32'hBAD0_0000, 32'd0, 1'b1, 1'b0, "id_retry_once");
    endtask

    task automatic test_latency();
        run_check(1, 0, 0, 32'd0, 32'd0, 1'b1, 1'b1, "latency3_extra_start");
    endtask

    task automatic test_back_to_back();
        run_check(0, 2, 1, 32'h0BAD_0001, 32'h0BAD_0002, 1'b0, 1'b0, "b2b_first");
        run_check(0, 0, 0, 32'd0, 32'd0, 1'b0, 1'b0, "b2b_second");
    endtask

    task automatic test_async_reset();
        sel = 1;
        do_reset();
        bad_id_n = 0;
        bad_ts_n = 0;
        start    = 1'b1;
        repeat (7) @(negedge clk);
        start = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({rd1, adr1, busy1, done1, pass1, fc1, ids1, tss1, rc1} !== '0) begin
            errors++;
            $display("FAIL async_reset: read=%0b addr=%0b busy=%0b id=%h rc=%0d, all required 0",
                     rd1, adr1, busy1, ids1, rc1);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || rd1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%0b done=%0b read=%0b, required all 0", busy1, done1, rd1);
        end
        run_check(1, 0, 0, 32'd0, 32'd0, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            run_check($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
                      EXP_ID ^ ($urandom | 32'h1), EXP_TS ^ ($urandom | 32'h1),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
        end
    endtask

`ifdef SYSID_CHK_PERIODIC_EN
    task automatic test_periodic();
        int rise, fall, rise2, fall2;
        bit pass_drop, busy_again;
        run_check(0, 0, 0, 32'd0, 32'd0, 1'b1, 1'b0, "periodic_first");
        rise      = -1;
        pass_drop = 1'b0;
        for (int n = 5; n <= 80 && rise < 0; n++) begin
            @(negedge clk);
            if (s_pass !== 1'b1) pass_drop = 1'b1;
            if (s_busy === 1'b1) rise = n;
        end
        checks++;
        if (rise != 4 + RC) begin
            errors++;
            $display("FAIL recheck_start: busy rose at %0d, required %0d", rise, 4 + RC);
        end
        fall = -1;
        for (int n = rise + 1; n <= rise + 40 && fall < 0; n++) begin
            @(negedge clk);
            if (s_pass !== 1'b1 || s_done !== 1'b1) pass_drop = 1'b1;
            if (s_busy === 1'b0) fall = n;
        end
        checks++;
        if (fall != rise + 3 || pass_drop) begin
            errors++;
            $display("FAIL recheck_pass: end at %0d pass_drop=%0b, required %0d pass_drop=0", fall,
                     pass_drop, rise + 3);
        end
        bad_ts_n   = 1000000;
        bad_ts_val = 32'h1234_5678;
        rise2      = -1;
        for (int n = fall + 1; n <= fall + 80 && rise2 < 0; n++) begin
            @(negedge clk);
            if (s_busy === 1'b1) rise2 = n;
        end
        fall2 = -1;
        for (int n = rise2 + 1; n <= rise2 + 40 && fall2 < 0; n++) begin
            @(negedge clk);
            if (s_busy === 1'b0) fall2 = n;
            else if (s_pass !== 1'b1) pass_drop = 1'b1;
        end
        checks++;
        if (rise2 != fall + RC || fall2 != rise2 + 9 || pass_drop) begin
            errors++;
            $display("FAIL recheck_fail_timing: rise=%0d end=%0d, required rise=%0d end=%0d",
                     rise2, fall2, fall + RC, fall + RC + 9);
        end
        checks++;
        if (s_pass !== 1'b0 || s_fc !== 2'b10 || s_done !== 1'b1 || s_rc !== 4'd2) begin
            errors++;
            $display("FAIL recheck_fail_result: pass=%0b fc=%b done=%0b rc=%0d, required 0 10 1 2",
                     s_pass, s_fc, s_done, s_rc);
        end
        busy_again = 1'b0;
        repeat (3 * RC) begin
            @(negedge clk);
            if (s_busy !== 1'b0) busy_again = 1'b1;
        end
        checks++;
        if (busy_again) begin
            errors++;
            $display("FAIL recheck_stops: busy=1 seen after failing recheck, required 0");
        end
    endtask
`endif

    initial begin
        test_reset();
        test_match();
        test_ts_mismatch();
        test_id_retry_once();
        test_latency();
        test_back_to_back();
        test_async_reset();
        test_random();
`ifdef SYSID_CHK_PERIODIC_EN
        test_periodic();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sysid_check_ctrl.md
Name: sysid_check_ctrl

Overview:
- Boot-time sequencer that owns the Avalon-MM master side of the system-ID slave.
- On `start`, it reads the ID word (address 0), then the timestamp word (address 1), and compares both against build-time expected values.
- It retries on mismatch, then reports pass/fail to the CPU-side status logic and the board LED/halt logic.
- It sits between the sysid slave and the boot supervisor, so software and hardware can refuse to run against a mismatched FPGA image.

Parameters:
- EXP_ID, 32'd0, expected word at address 0
- EXP_TIMESTAMP, 32'd1393714090, expected word at address 1
- READ_LATENCY, 0, cycles from av_read to valid av_readdata (0 = same cycle, combinational slave); legal range 0-7
- MAX_RETRIES, 2, extra full ID+timestamp attempts after the first mismatch; legal range 0-15
- RECHECK_CYCLES, 1000000, period of the automatic re-check (used only with the optional feature)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to run a check
- av_address  out  1  sysid word select
- av_read  out  1  read strobe, one cycle per word
- av_readdata  in  32  sysid read data
- busy  out  1  check in progress
- done  out  1  sticky; a result is valid
- pass  out  1  last check matched both words
- fail_code  out  2  bit0 = ID mismatch, bit1 = timestamp mismatch (values from the last attempt)
- id_seen  out  32  captured ID word
- ts_seen  out  32  captured timestamp word
- retry_cnt  out  4  retries used in the last check

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - On reset, every output and register is 0 and the state is IDLE.
  - Reset mid-check aborts immediately; no partial result survives.
- States: IDLE, RD_ID, WT_ID, RD_TS, WT_TS, CMP, DONE.
- IDLE: `start` moves to RD_ID next cycle. On that same edge:
  - busy=1, done=0, pass=0, fail_code=0, retry_cnt=0.
- RD_ID: one cycle, av_read=1, av_address=0.
  - READ_LATENCY=0: capture av_readdata into id_seen this cycle, then go to RD_TS.
  - Otherwise go to WT_ID.
- WT_ID: a down-counter loaded with READ_LATENCY counts the wait.
  - av_read=0.
  - id_seen is captured on the cycle that is READ_LATENCY cycles after RD_ID, then go to RD_TS.
- RD_TS / WT_TS: identical to RD_ID / WT_ID, with av_address=1 and capture into ts_seen.
- av_read is 0 and av_address holds its last value in all other states.
- CMP: one cycle.
  - Computes fail_code = {ts_seen!=EXP_TIMESTAMP, id_seen!=EXP_ID}.
  - Match: go to DONE with pass=1.
  - Mismatch with retry_cnt<MAX_RETRIES: increment retry_cnt and go to RD_ID.
  - Mismatch with retry_cnt==MAX_RETRIES: go to DONE with pass=0.
- DONE: busy=0, done=1.
  - Results hold until the next `start`.
  - `start` in DONE behaves as in IDLE.
- Latency with READ_LATENCY=L and a first-try match:
  - `start` at cycle 0; done=1 and busy=0 from cycle 4+2L.
  - Each retry adds 3+2L cycles.
- `start` while busy is ignored. Counters saturate and never wrap.

Optional Feature:
- Macro: SYSID_CHK_PERIODIC_EN.
- Defined:
  - A 32-bit counter runs in DONE only while pass=1.
  - After RECHECK_CYCLES cycles in DONE, the block self-starts as if `start` had been pulsed, except done, pass and fail_code are NOT cleared.
  - Those three update only at the next CMP that leads to DONE.
  - busy=1 during the re-check.
  - A failing result stops further re-checks.
  - The counter resets on any exit from DONE.
- Undefined: no counter is built; DONE holds until `start`.

Decomposition:
- Package sysid_chk_pkg holds:
  - state enum type
  - fail_code bit-index constants FC_ID=0, FC_TS=1
  - ADDR_ID=1'b0, ADDR_TS=1'b1
- One natural sub-module, sysid_chk_rd_port.
  - Issues one read and waits READ_LATENCY cycles.
  - Ports: go, addr, rd_done, rd_data.
  - Reused for both words.
- The FSM, comparison, retry counter and optional re-check timer stay in sysid_check_ctrl.

Test Plan:
1. Matching slave (addr0→0, addr1→1393714090), L=0, start at cycle 0 → av_read high at cycles 1-2, done=1, pass=1, fail_code=0, retry_cnt=0 at cycle 4.
2. Slave returns 32'h12345678 on addr1, MAX_RETRIES=2 → three attempts, then done=1, pass=0, fail_code=2'b10, retry_cnt=2, ts_seen=32'h12345678 at cycle 4+2*3=10.
3. Slave mismatches ID on the first attempt only → pass=1, retry_cnt=1, done at cycle 7.
4. L=3, matching slave → captures occur 3 cycles after each read strobe; done at cycle 10. Extra `start` pulses at cycles 2 and 5 are ignored.
5. Reset asserted asynchronously mid-WT_TS → all outputs 0 within the same cycle, state IDLE; a later `start` completes normally.
6. With SYSID_CHK_PERIODIC_EN and RECHECK_CYCLES=20: after the first pass, busy rises 20 cycles into DONE and pass stays 1 throughout. The slave is then changed to mismatch → the next re-check ends pass=0 and no further re-check occurs.
